axis_frame_arbiter: RTL and testbench
=====================================

# axis_frame_arbiter

Frame-granular round-robin arbiter that shares one AXI-stream video sink, typically a VDMA write channel, between NUM_SRC native-to-AXIS video sources. It switches sources only on frame boundaries: a frame starts on a tuser (SOF) beat and ends on the VLINES-th tlast. It also resynchronises idle sources to their next SOF. It sits between the per-source stream converters and the single downstream stream consumer.

## Interface
- NUM_SRC, 4: number of source streams (2..8)
- DSIZE, 24: tdata width
- VLINES, 1080: active lines per frame, i.e. tlast handshakes per frame
- clock  in  1  stream clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- src_en  in  NUM_SRC  per-source arbitration enable, sampled only in ARB
- s_tdata  in  NUM_SRC*DSIZE  source data, source i at [i*DSIZE +: DSIZE]
- s_tvalid  in  NUM_SRC  source valid
- s_tuser  in  NUM_SRC  source SOF flag
- s_tlast  in  NUM_SRC  source end-of-line flag
- s_tready  out  NUM_SRC  source ready
- m_tdata  out  DSIZE  sink data
- m_tvalid  out  1  sink valid
- m_tuser  out  1  sink SOF
- m_tlast  out  1  sink EOL
- m_tready  in  1  sink ready
- grant  out  $clog2(NUM_SRC)  currently granted source
- grant_valid  out  1  high while in STREAM
- frame_done  out  1  one-cycle pulse on completed frame
- err_sof  out  1  one-cycle pulse on premature SOF
- frame_cnt  out  16  completed frames, wraps at 0xFFFF→0

## Operation
- States: ARB and STREAM.
- Request: req[i] = src_en[i] & s_tvalid[i] & s_tuser[i], i.e. an enabled source presenting an SOF beat.
- ARB state:
  - All m_* outputs are gated low (m_tvalid=0).
  - Requesting sources have s_tready=0, so their SOF beat is held.
  - Enabled sources presenting a non-SOF beat get s_tready=1, which discards the beat so the source advances to its next SOF.
  - Disabled sources get s_tready=1 and are discarded.
  - If any req is set: the winner is the first requester searching upward from last_grant+1, modulo NUM_SRC. The winner is registered into grant and last_grant, line_cnt is cleared, and the state goes to STREAM.
- STREAM state:
  - m_* outputs are a combinational mux of source grant.
  - s_tready[grant] = m_tready.
  - Every other source has s_tready=0. src_en is ignored, so a source disabled mid-frame still finishes its frame.
- Line counting and frame end:
  - A tlast handshake (m_tvalid & m_tready & m_tlast) increments line_cnt.
  - On the handshake where line_cnt == VLINES-1: pulse frame_done, increment frame_cnt, return to ARB.
- Premature SOF:
  - Trigger: a handshake carrying m_tuser=1 other than the first beat of the grant.
  - Response: pulse err_sof and clear line_cnt to 0, counting this beat's tlast if one is set. The beat is forwarded as the start of a new frame and the grant is kept.
- A beat with both tuser and tlast counts as the first line.
- Reset values: state=ARB, grant=0, last_grant=NUM_SRC-1 (so source 0 wins first), grant_valid=0, line_cnt=0, frame_cnt=0, frame_done=0, err_sof=0.
- Reset mid-frame abandons the frame with no frame_done. The sink sees a truncated frame; resync is the sink's job.

## Timing
- Datapath latency is 0 cycles: combinational mux, no registers on tdata.
- Arbitration bubble: one cycle per frame. A req seen in ARB at cycle N gives grant_valid=1 and m_tvalid for the SOF beat at N+1.
- After the final tlast handshake at cycle N: ARB at N+1, earliest next SOF forwarded at N+2.
- frame_done and err_sof are registered, asserted the cycle after the qualifying handshake, for exactly 1 cycle.
- grant and grant_valid are registered; both are stable throughout STREAM.
- No combinational path from m_tready to m_tvalid. The s_tready path from m_tready is combinational in STREAM.
- The m_tvalid and m_tdata hold rule passes through from the source, which must obey AXIS stability.

## Structure
- Package axis_frame_arb_pkg:
  - state enum {ARB, STREAM}
  - GRANT_W = $clog2(NUM_SRC) helper
  - function rr_pick(req, last) returning the winner index.
- Sub-module rr_arbiter (req, last_grant → winner, any_req): combinational round-robin picker, reusable by other shared-resource controllers.
- The top level holds the FSM, counters and the stream muxes.

## Test plan
- Two sources, both enabled, SOF presented simultaneously after reset → source 0 granted first. After VLINES tlasts, frame_done=1 and frame_cnt=1; source 1 is granted next, with a 1-cycle bubble. Order continues 0,1,0,1.
- Source 2 comes out of reset mid-frame (non-SOF beats, tuser=0), other sources idle → those beats see s_tready=1 and are dropped, m_tvalid stays 0. Its first SOF beat is forwarded one cycle after being presented.
- VLINES=4, granted source raises tuser on line 3 → err_sof pulses once, frame continues. frame_done fires only after 4 further tlasts.
- m_tready held low for 10 cycles mid-line → s_tready[grant]=0 and line_cnt unchanged. All 4 lines are delivered with no beat lost or duplicated (scoreboard compares tdata sequences).
- src_en[grant] deasserted mid-frame → frame completes to VLINES lines. That source is not regranted while src_en=0 and its beats are drained with s_tready=1.
- rst asserted mid-frame at line 2 → the next cycle shows grant_valid=0, line_cnt=0, frame_cnt=0, no frame_done. After release, source 0 wins on the next SOF. Also check frame_cnt wrap by forcing 0xFFFF → 0.

Source files
------------

// File: rtl/axis_frame_arb_pkg.sv
// rtl/axis_frame_arb_pkg.sv - shared types and round-robin helper for the frame arbiter
package axis_frame_arb_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    STREAM = 1'b1
  } arb_state_t;

  localparam int MAX_SRC = 8;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Walk from the farthest offset down so the nearest requester above last wins.
  function automatic int rr_pick(input logic [MAX_SRC-1:0] req, input int last, input int n);
    int win;
    int idx;
    win = last;
    for (int k = n; k >= 1; k--) begin
      idx = (last + k) % n;
      if (req[idx]) win = idx;
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker over N requesters
module rr_arbiter
  import axis_frame_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = grant_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last_grant,
  output logic [W-1:0] winner,
  output logic         any_req
);

  logic [MAX_SRC-1:0] req_ext;

  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
  end

  assign winner  = W'(rr_pick(req_ext, int'(last_grant), N));
  assign any_req = |req;

endmodule

// File: rtl/axis_frame_arbiter.sv
// rtl/axis_frame_arbiter.sv - frame-granular round-robin arbiter sharing one AXIS video sink
module axis_frame_arbiter
  import axis_frame_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DSIZE   = 24,
  parameter int VLINES  = 1080
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic [NUM_SRC-1:0]         src_en,
  input  logic [NUM_SRC*DSIZE-1:0]   s_tdata,
  input  logic [NUM_SRC-1:0]         s_tvalid,
  input  logic [NUM_SRC-1:0]         s_tuser,
  input  logic [NUM_SRC-1:0]         s_tlast,
  output logic [NUM_SRC-1:0]         s_tready,
  output logic [DSIZE-1:0]           m_tdata,
  output logic                       m_tvalid,
  output logic                       m_tuser,
  output logic                       m_tlast,
  input  logic                       m_tready,
  output logic [$clog2(NUM_SRC)-1:0] grant,
  output logic                       grant_valid,
  output logic                       frame_done,
  output logic                       err_sof,
  output logic [15:0]                frame_cnt
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int LW = $clog2(VLINES + 1);

  arb_state_t        state;
  logic [GW-1:0]     grant_q;
  logic [GW-1:0]     last_grant;
  logic [LW-1:0]     line_cnt;
  logic              first_beat;
  logic [15:0]       frame_cnt_q;
  logic              frame_done_q;
  logic              err_sof_q;

  logic [NUM_SRC-1:0] req;
  logic [GW-1:0]      winner;
  logic               any_req;
  logic               hs;
  logic               early_sof;
  logic               frame_end;
  logic [LW-1:0]      line_base;

  assign req = src_en & s_tvalid & s_tuser;

  rr_arbiter #(
    .N (NUM_SRC),
    .W (GW)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .winner     (winner),
    .any_req    (any_req)
  );

  // In ARB, everything except a held SOF request is drained so idle sources resync.
  always_comb begin
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tuser  = 1'b0;
    m_tlast  = 1'b0;
    s_tready = ~req;
    if (state == STREAM) begin
      m_tdata           = s_tdata[int'(grant_q)*DSIZE +: DSIZE];
      m_tvalid          = s_tvalid[grant_q];
      m_tuser           = s_tuser[grant_q];
      m_tlast           = s_tlast[grant_q];
      s_tready          = '0;
      s_tready[grant_q] = m_tready;
    end
  end

  assign hs        = m_tvalid & m_tready;
  assign early_sof = hs & m_tuser & ~first_beat;
  assign line_base = early_sof ? '0 : line_cnt;
  assign frame_end = hs & m_tlast & (line_base == LW'(VLINES - 1));

  always_ff @(posedge clock) begin
    if (rst) begin
      state        <= ARB;
      grant_q      <= '0;
      last_grant   <= GW'(NUM_SRC - 1);
      line_cnt     <= '0;
      first_beat   <= 1'b0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      err_sof_q    <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      err_sof_q    <= 1'b0;
      case (state)
        ARB: begin
          if (any_req) begin
            grant_q    <= winner;
            last_grant <= winner;
            line_cnt   <= '0;
            first_beat <= 1'b1;
            state      <= STREAM;
          end
        end
        STREAM: begin
          if (hs) begin
            first_beat <= 1'b0;
            err_sof_q  <= early_sof;
            if (frame_end) begin
              frame_done_q <= 1'b1;
              frame_cnt_q  <= frame_cnt_q + 16'd1;
              line_cnt     <= '0;
              state        <= ARB;
            end else begin
              line_cnt <= line_base + LW'(m_tlast);
            end
          end
        end
        default: state <= ARB;
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = (state == STREAM);
  assign frame_done  = frame_done_q;
  assign err_sof     = err_sof_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb/tb_axis_frame_arbiter.sv - randomized self-checking bench with frame-level reference model
module tb_axis_frame_arbiter;

  localparam int NS = 4;
  localparam int DW = 24;
  localparam int VL = 4;

  logic              clock = 1'b0;
  logic              rst   = 1'b1;
  logic [NS-1:0]     src_en = '1;
  logic [NS*DW-1:0]  s_tdata = '0;
  logic [NS-1:0]     s_tvalid = '0;
  logic [NS-1:0]     s_tuser = '0;
  logic [NS-1:0]     s_tlast = '0;
  logic [NS-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tuser;
  logic              m_tlast;
  logic              m_tready = 1'b1;
  logic [1:0]        grant;
  logic              grant_valid;
  logic              frame_done;
  logic              err_sof;
  logic [15:0]       frame_cnt;

  always #5 clock = ~clock;

  axis_frame_arbiter #(.NUM_SRC(NS), .DSIZE(DW), .VLINES(VL)) dut (
    .clock(clock), .rst(rst), .src_en(src_en),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tuser(s_tuser), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tready(m_tready),
    .grant(grant), .grant_valid(grant_valid), .frame_done(frame_done), .err_sof(err_sof),
    .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic u;
    logic l;
    logic eof;
    logic perr;
    int   src;
  } beat_t;

  beat_t src_q[NS][$];
  beat_t exp_q[$];

  int vectors = 0, miscompares = 0, cyc = 0;
  int fd_seen = 0, err_seen = 0, sink_beats = 0, sink_lines = 0, model_frames = 0;
  int model_last = NS - 1;
  bit pend_fd = 0, pend_err = 0, rdy_force = 0, rdy_val = 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic bit busy();
    bit b = (exp_q.size() > 0);
    for (int i = 0; i < NS; i++) if (src_q[i].size() > 0) b = 1;
    return b;
  endfunction

  // Frame builder: tuser on the first beat of line 0 and of err_line; eof marks the VL-th tlast since the last SOF.
  task automatic gen_frame(input int s, input int nlines, input int err_line, input bit to_exp);
    beat_t b;
    int cnt, len;
    cnt = 0;
    for (int ln = 0; ln < nlines; ln++) begin
      len = $urandom_range(1, 3);
      for (int k = 0; k < len; k++) begin
        b.d    = DW'($urandom);
        b.src  = s;
        b.perr = (ln == err_line) && (k == 0) && (ln > 0);
        b.u    = (k == 0) && (ln == 0 || ln == err_line);
        b.l    = (k == len - 1);
        if (b.u) cnt = 0;
        if (b.l) cnt++;
        b.eof  = b.l && (cnt == VL);
        src_q[s].push_back(b);
        if (to_exp) exp_q.push_back(b);
      end
    end
  endtask

  task automatic gen_junk(input int s, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = DW'($urandom); b.src = s; b.u = 1'b0; b.l = k[0]; b.eof = 1'b0; b.perr = 1'b0;
      src_q[s].push_back(b);
    end
  endtask

  task automatic step();
    logic [NS-1:0] exp_rdy;
    beat_t e;
    @(negedge clock);
    for (int i = 0; i < NS; i++) begin
      if (src_q[i].size() > 0) begin
        s_tvalid[i] = 1'b1;
        s_tuser[i]  = src_q[i][0].u;
        s_tlast[i]  = src_q[i][0].l;
        s_tdata[i*DW +: DW] = src_q[i][0].d;
      end else begin
        s_tvalid[i] = 1'b0;
        s_tuser[i]  = 1'b0;
        s_tlast[i]  = 1'b0;
        s_tdata[i*DW +: DW] = '0;
      end
    end
    m_tready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
    #2;
    check("frame_done", frame_done, pend_fd);
    check("err_sof", err_sof, pend_err);
    if (pend_fd) begin
      check("bubble_grant_valid", grant_valid, 0);
      check("bubble_m_tvalid", m_tvalid, 0);
    end
    fd_seen  += int'(frame_done);
    err_seen += int'(err_sof);
    pend_fd  = 0;
    pend_err = 0;
    if (grant_valid) exp_rdy = m_tready ? (NS'(1) << grant) : '0;
    else             exp_rdy = ~(src_en & s_tvalid & s_tuser);
    check("s_tready", s_tready, exp_rdy);
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", m_tdata, 0);
      end else begin
        e = exp_q.pop_front();
        check("beat", {grant, m_tuser, m_tlast, m_tdata}, {2'(e.src), e.u, e.l, e.d});
        pend_fd  = e.eof;
        pend_err = e.perr;
      end
      sink_beats++;
      if (m_tlast) sink_lines++;
    end
    for (int i = 0; i < NS; i++)
      if (s_tvalid[i] && s_tready[i]) void'(src_q[i].pop_front());
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step();
      n++;
    end
    check("drain_complete", busy(), 0);
    step();
    step();
  endtask

  initial begin
    int n, t0, fd0, err0, bs, lines0;
    repeat (3) @(negedge clock);
    rst = 1'b0;
    #2;
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant", grant, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_sof", err_sof, 0);
    check("rst_s_tready", s_tready, 4'hF);

    // All sources backlogged: strict rotation starting at source 0.
    for (int k = 0; k < 12; k++) begin
      model_last = (model_last + 1) % NS;
      gen_frame(model_last, VL, -1, 1);
    end
    drain(2000);
    model_frames += 12;
    check("rr_frame_cnt", frame_cnt, model_frames);
    check("rr_frame_done_count", fd_seen, model_frames);

    // Source 2 wakes mid-frame: junk dropped, SOF forwarded one cycle after presentation.
    rdy_force = 1; rdy_val = 1;
    gen_junk(2, 3);
    gen_frame(2, VL, -1, 1);
    n = 0;
    while (!(src_q[2].size() > 0 && src_q[2][0].u) && n < 20) begin step(); n++; end
    step();
    t0 = cyc;
    check("sof_held_m_tvalid", m_tvalid, 0);
    check("sof_held_s_tready", s_tready[2], 0);
    step();
    check("sof_fwd_latency", cyc - t0, 1);
    check("sof_fwd_m_tvalid", m_tvalid, 1);
    check("sof_fwd_grant_valid", grant_valid, 1);
    drain(500);
    rdy_force = 0;
    model_frames++;

    // Premature SOF on line 3: err_sof once, frame restarts and needs 4 more lines.
    fd0 = fd_seen; err0 = err_seen;
    gen_frame(0, 6, 2, 1);
    drain(500);
    model_frames++;
    check("early_sof_pulses", err_seen - err0, 1);
    check("early_sof_frames", fd_seen - fd0, 1);
    check("early_sof_frame_cnt", frame_cnt, model_frames);

    // Sink stall for 10 cycles mid-frame.
    rdy_force = 1; rdy_val = 1;
    lines0 = sink_lines;
    bs = sink_beats;
    gen_frame(1, VL, -1, 1);
    n = 0;
    while (sink_beats < bs + 2 && n < 50) begin step(); n++; end
    rdy_val = 0;
    bs = sink_beats;
    repeat (10) step();
    check("stall_beats", sink_beats, bs);
    check("stall_line_cnt", dut.line_cnt, sink_lines - lines0);
    rdy_val = 1;
    drain(500);
    rdy_force = 0;
    model_frames++;

    // Granted source disabled mid-frame: frame completes, later frames drained not granted.
    gen_frame(1, VL, -1, 1);
    gen_frame(1, VL, -1, 0);
    n = 0;
    while (!grant_valid && n < 20) begin step(); n++; end
    check("disable_grant", grant, 1);
    src_en[1] = 1'b0;
    gen_frame(3, VL, -1, 1);
    drain(1000);
    src_en[1] = 1'b1;
    model_frames += 2;
    check("disable_frame_cnt", frame_cnt, model_frames);

    // Frame counter wrap.
    force dut.frame_cnt_q = 16'hFFFF;
    step();
    release dut.frame_cnt_q;
    gen_frame(0, VL, -1, 1);
    drain(500);
    model_frames = 0;
    check("wrap_frame_cnt", frame_cnt, 0);

    // Reset in the middle of a frame.
    lines0 = sink_lines;
    gen_frame(2, VL, -1, 1);
    n = 0;
    while (sink_lines < lines0 + 2 && n < 100) begin step(); n++; end
    rst = 1'b1;
    for (int i = 0; i < NS; i++) src_q[i].delete();
    exp_q.delete();
    fd0 = fd_seen;
    step();
    rst = 1'b0;
    step();
    check("midrst_grant_valid", grant_valid, 0);
    check("midrst_line_cnt", dut.line_cnt, 0);
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_no_frame_done", fd_seen - fd0, 0);
    gen_frame(0, VL, -1, 1);
    gen_frame(2, VL, -1, 1);
    drain(500);
    check("post_rst_frame_cnt", frame_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
